// File: rtl/hazard_forward_unit.sv
// Operand forwarding and load-use interlock for an in-order pipeline.
// Ports: issue_* / rs*_sel / rf_src* in; stage_data in; src*_out, fwd*_hit, stall, counters out.
module hazard_forward_unit #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int DEPTH = 3,
  parameter int CNTW  = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  input  logic                  issue_regwrt,
  input  logic                  issue_late,
  input  logic [AW-1:0]         rs1_sel,
  input  logic [AW-1:0]         rs2_sel,
  input  logic [XLEN-1:0]       rf_src1,
  input  logic [XLEN-1:0]       rf_src2,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  input  logic                  flush,
  output logic [XLEN-1:0]       src1_out,
  output logic [XLEN-1:0]       src2_out,
  output logic                  fwd1_hit,
  output logic                  fwd2_hit,
  output logic                  stall,
  output logic [CNTW-1:0]       stall_cnt,
  output logic [CNTW-1:0]       fwd_cnt
);

  localparam int LATE_STAGE = 1;

  logic [DEPTH-1:0]         v_q, v_d;
  logic [DEPTH-1:0]         wr_q, wr_d;
  logic [DEPTH-1:0]         late_q, late_d;
  logic [DEPTH-1:0][AW-1:0] rd_q, rd_d;
  logic [CNTW-1:0]          stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0]          fwd_cnt_q, fwd_cnt_d;

  logic [DEPTH-1:0] prod;
  logic             m1, m2, l1, l2;
  logic [XLEN-1:0]  d1, d2;
  logic             issue_go;
  logic [1:0]       fwd_inc;
  logic [CNTW:0]    fwd_sum;

  // Lookup: scan oldest to youngest so the youngest match wins,
  // whether or not it is ready. Reset masks the pipe as empty.
  always_comb begin
    m1 = 1'b0;
    m2 = 1'b0;
    l1 = 1'b0;
    l2 = 1'b0;
    d1 = rf_src1;
    d2 = rf_src2;
    for (int k = 0; k < DEPTH; k++) begin
      prod[k] = v_q[k] && wr_q[k] && (rd_q[k] != '0) && !reset;
    end
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (prod[k] && rd_q[k] == rs1_sel) begin
        m1 = 1'b1;
        l1 = late_q[k] && (k < LATE_STAGE);
        d1 = stage_data[k*XLEN +: XLEN];
      end
      if (prod[k] && rd_q[k] == rs2_sel) begin
        m2 = 1'b1;
        l2 = late_q[k] && (k < LATE_STAGE);
        d2 = stage_data[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    fwd1_hit = m1 && !l1;
    fwd2_hit = m2 && !l2;
    src1_out = fwd1_hit ? d1 : rf_src1;
    src2_out = fwd2_hit ? d2 : rf_src2;
    stall    = issue_valid && !flush && ((m1 && l1) || (m2 && l2));
    issue_go = issue_valid && !stall && !flush;
  end

  // Pipe shift: never stalls; a held issue becomes a bubble.
  always_comb begin
    v_d[0]    = issue_go;
    rd_d[0]   = issue_rd;
    wr_d[0]   = issue_regwrt;
    late_d[0] = issue_late;
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k]    = v_q[k-1];
      rd_d[k]   = rd_q[k-1];
      wr_d[k]   = wr_q[k-1];
      late_d[k] = late_q[k-1];
    end
  end

  // Saturating counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != {CNTW{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    fwd_inc   = {1'b0, fwd1_hit} + {1'b0, fwd2_hit};
    fwd_sum   = {1'b0, fwd_cnt_q} + (CNTW+1)'(fwd_inc);
    fwd_cnt_d = fwd_cnt_q;
    if (issue_go) begin
      fwd_cnt_d = fwd_sum[CNTW] ? {CNTW{1'b1}} : fwd_sum[CNTW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q         <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      late_q      <= '0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      v_q         <= v_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      late_q      <= late_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: vector table plus hand sequences.
// Main instance DEPTH=3 CNTW=4; second instance DEPTH=1.
module tb_hazard_forward_unit;

  localparam logic [31:0] RF1 = 32'h1000_0001;
  localparam logic [31:0] RF2 = 32'h2000_0002;
  localparam logic [31:0] SD0 = 32'h0000_0011;
  localparam logic [31:0] SD1 = 32'h0000_000B;
  localparam logic [31:0] SD2 = 32'h0000_00C2;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [4:0]  rd;
    logic        wr;
    logic        late;
    logic        flush;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e_src1;
    logic [31:0] e_src2;
    logic        e_h1;
    logic        e_h2;
    logic        e_st;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_regwrt, issue_late, flush;
  logic [4:0]  issue_rd, rs1_sel, rs2_sel;
  logic [31:0] rf_src1, rf_src2;
  logic [95:0] stage_data;
  logic [31:0] src1_out, src2_out;
  logic        fwd1_hit, fwd2_hit, stall;
  logic [3:0]  stall_cnt, fwd_cnt;
  logic [31:0] o1_src1, o1_src2;
  logic        o1_h1, o1_h2, o1_stall;
  logic [3:0]  o1_sc, o1_fc;

  int checks = 0;
  int errors = 0;
  vec_t exp_q[$];
  vec_t vecs[15];
  int sc_m, fc_m;

  always #5 clk = ~clk;

  hazard_forward_unit #(.XLEN(32), .NREG(32), .DEPTH(3), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_regwrt(issue_regwrt),
    .issue_late(issue_late), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .stage_data(stage_data),
    .flush(flush), .src1_out(src1_out), .src2_out(src2_out),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .stall(stall),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  hazard_forward_unit #(.XLEN(32), .NREG(32), .DEPTH(1), .CNTW(4)) dut1 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_regwrt(issue_regwrt),
    .issue_late(issue_late), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .stage_data(SD0),
    .flush(flush), .src1_out(o1_src1), .src2_out(o1_src2),
    .fwd1_hit(o1_h1), .fwd2_hit(o1_h2), .stall(o1_stall),
    .stall_cnt(o1_sc), .fwd_cnt(o1_fc)
  );

  function automatic vec_t mk(
    logic r, logic v, logic [4:0] rd, logic w, logic l, logic f,
    logic [4:0] s1, logic [4:0] s2, logic [31:0] e1, logic [31:0] e2,
    logic h1, logic h2, logic st);
    vec_t x;
    x.rst = r; x.valid = v; x.rd = rd; x.wr = w; x.late = l;
    x.flush = f; x.rs1 = s1; x.rs2 = s2; x.e_src1 = e1;
    x.e_src2 = e2; x.e_h1 = h1; x.e_h2 = h2; x.e_st = st;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v, string tag);
    vec_t e;
    @(negedge clk);
    reset        = v.rst;
    issue_valid  = v.valid;
    issue_rd     = v.rd;
    issue_regwrt = v.wr;
    issue_late   = v.late;
    flush        = v.flush;
    rs1_sel      = v.rs1;
    rs2_sel      = v.rs2;
    exp_q.push_back(v);
    #1;
    e = exp_q.pop_front();
    chk({tag, " src1"}, src1_out, e.e_src1);
    chk({tag, " src2"}, src2_out, e.e_src2);
    chk({tag, " hit1"}, 32'(fwd1_hit), 32'(e.e_h1));
    chk({tag, " hit2"}, 32'(fwd2_hit), 32'(e.e_h2));
    chk({tag, " stall"}, 32'(stall), 32'(e.e_st));
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0; issue_rd = '0; issue_regwrt = 1'b0;
    issue_late = 1'b0; flush = 1'b0; rs1_sel = '0; rs2_sel = '0;
    rf_src1 = RF1; rf_src2 = RF2;
    stage_data = {SD2, SD1, SD0};

    vecs[0]  = mk(1,0, 0,0,0,0,  0, 0, RF1,RF2,0,0,0);
    vecs[1]  = mk(0,1, 5,1,0,0,  1, 2, RF1,RF2,0,0,0);
    vecs[2]  = mk(0,1, 7,1,0,0,  5, 6, SD0,RF2,1,0,0);
    vecs[3]  = mk(0,1, 7,1,0,0,  5, 7, SD1,SD0,1,1,0);
    vecs[4]  = mk(0,1, 0,1,0,0,  5, 7, SD2,SD0,1,1,0);
    vecs[5]  = mk(0,1, 3,1,1,0,  0, 0, RF1,RF2,0,0,0);
    vecs[6]  = mk(0,1, 8,1,0,0,  3, 7, RF1,SD2,0,1,1);
    vecs[7]  = mk(0,1, 8,1,0,0,  3, 7, SD1,RF2,1,0,0);
    vecs[8]  = mk(0,1, 9,1,0,1,  8, 3, SD0,SD2,1,1,0);
    vecs[9]  = mk(0,1,10,0,0,0,  9, 8, RF1,SD1,0,1,0);
    vecs[10] = mk(0,1, 4,1,1,0, 10, 8, RF1,SD2,0,1,0);
    vecs[11] = mk(0,1, 0,0,0,1,  4, 0, RF1,RF2,0,0,0);
    vecs[12] = mk(0,0, 0,0,0,0,  4,10, SD1,RF2,1,0,0);
    vecs[13] = mk(1,1, 6,1,0,0,  4, 0, RF1,RF2,0,0,0);
    vecs[14] = mk(0,1, 6,1,0,0,  6, 4, RF1,RF2,0,0,0);

    @(negedge clk);
    @(negedge clk);
    sc_m = 0;
    fc_m = 0;
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
      chk($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), sc_m);
      chk($sformatf("vec%0d fwd_cnt", i), 32'(fwd_cnt), fc_m);
      if (vecs[i].rst) begin
        sc_m = 0;
        fc_m = 0;
      end else begin
        if (vecs[i].e_st && sc_m < 15) sc_m++;
        if (vecs[i].valid && !vecs[i].e_st && !vecs[i].flush) begin
          fc_m += int'(vecs[i].e_h1) + int'(vecs[i].e_h2);
          if (fc_m > 15) fc_m = 15;
        end
      end
    end

    // Stall counter saturation: 20 load-use stalls.
    apply(mk(1,0,0,0,0,0, 0,0, RF1,RF2,0,0,0), "sat rst");
    for (int i = 0; i < 20; i++) begin
      apply(mk(0,1,3,1,1,0, 0,0, RF1,RF2,0,0,0), "sat ld");
      apply(mk(0,1,0,0,0,0, 3,0, RF1,RF2,0,0,1), "sat use");
    end
    apply(mk(0,1,5,1,0,0, 0,0, RF1,RF2,0,0,0), "sat end");
    chk("sat stall_cnt", 32'(stall_cnt), 32'd15);
    apply(mk(1,0,0,0,0,0, 5,5, RF1,RF2,0,0,0), "rst mask");
    apply(mk(0,0,0,0,0,0, 5,5, RF1,RF2,0,0,0), "post rst");
    chk("post rst stall_cnt", 32'(stall_cnt), 32'd0);
    chk("post rst fwd_cnt", 32'(fwd_cnt), 32'd0);

    // DEPTH=1: late match stalls, then reads RF.
    apply(mk(0,1,3,1,1,0, 0,0, RF1,RF2,0,0,0), "d1 ld");
    chk("d1 ld stall", 32'(o1_stall), 32'd0);
    apply(mk(0,1,0,0,0,0, 3,0, RF1,RF2,0,0,1), "d1 use");
    chk("d1 use stall", 32'(o1_stall), 32'd1);
    apply(mk(0,1,5,1,0,0, 3,0, SD1,RF2,1,0,0), "d1 after");
    chk("d1 after stall", 32'(o1_stall), 32'd0);
    chk("d1 after hit1", 32'(o1_h1), 32'd0);
    chk("d1 after src1", o1_src1, RF1);
    apply(mk(0,1,0,0,0,0, 5,0, SD0,RF2,1,0,0), "d1 alu");
    chk("d1 alu hit1", 32'(o1_h1), 32'd1);
    chk("d1 alu src1", o1_src1, SD0);
    chk("d1 stall_cnt", 32'(o1_sc), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
